// File: rtl/adc_pkg.sv
// Shared constants, load-source enum and the lane-split helper for the
// two-lane ADC transmit serializer.
package adc_pkg;

  localparam int          ADC_LANES            = 2;
  localparam int          SAMPLE_W_DEFAULT     = 16;
  localparam logic [15:0] IDLE_PATTERN_DEFAULT = 16'hA5A5;

  // Largest sample the lane-split helper can take apart.
  localparam int MAX_SAMPLE_W = 64;
  localparam int MAX_LANE_W   = MAX_SAMPLE_W / ADC_LANES;

  typedef logic [MAX_LANE_W-1:0] lane_word_t;

  typedef enum logic [1:0] {
    LOAD_NONE,
    LOAD_HOLD,
    LOAD_BYPASS,
    LOAD_IDLE
  } load_src_e;

  // Lane 1 gets the odd sample bits and lane 0 gets the even bits.
  // Bit i of the result is sample bit 2*i+lane, so the MSB of each lane
  // word is the highest sample bit of that parity.
  function automatic lane_word_t lane_bits(input logic [MAX_SAMPLE_W-1:0] d,
                                           input int lane);
    lane_word_t w;
    w = '0;
    for (int i = 0; i < MAX_LANE_W; i++) begin
      w[i] = d[2*i + lane];
    end
    return w;
  endfunction

endpackage

// File: rtl/adc_lane_shift.sv
// N-bit parallel-load shift register that presents its MSB first.
// One instance drives each serial lane.
module adc_lane_shift #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [N-1:0] i_data,
  output logic         o_bit
);

  logic [N-1:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
    end else begin
      r_shift <= {r_shift[N-2:0], 1'b0};
    end
  end

  assign o_bit = r_shift[N-1];

endmodule

// File: rtl/adc_lane_tx.sv
// Two-lane ADC transmit serializer. It takes samples over valid/ready and
// sends them bit-interleaved on two lanes in free-running frames.
module adc_lane_tx
  import adc_pkg::*;
#(
  parameter int                  SAMPLE_W     = SAMPLE_W_DEFAULT,
  parameter logic [SAMPLE_W-1:0] IDLE_PATTERN = SAMPLE_W'(IDLE_PATTERN_DEFAULT)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [SAMPLE_W-1:0] i_s_data,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  input  logic                i_clear_underrun,
  output logic                o_ln0,
  output logic                o_ln1,
  output logic                o_fr,
  output logic                o_frame_start,
  output logic                o_underrun
);

  localparam int            N        = SAMPLE_W / ADC_LANES;
  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam int            FR_BITS  = (N + 1) / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_next;
  logic                r_hold_full;
  logic [SAMPLE_W-1:0] r_hold;
  logic                r_fr;
  logic                r_frame_start;
  logic                r_underrun;

  logic                w_xfer;
  logic                w_load_edge;
  load_src_e           w_src;
  logic [SAMPLE_W-1:0] w_load_word;
  logic [N-1:0]        w_lane0_word;
  logic [N-1:0]        w_lane1_word;

  assign o_s_ready   = ~r_hold_full & ~i_rst;
  assign w_xfer      = i_s_valid & o_s_ready;
  assign w_load_edge = (r_cnt == CNT_LAST);
  assign w_cnt_next  = w_load_edge ? '0 : r_cnt + CW'(1);

  // A held sample goes out first. An empty holding register lets an incoming
  // sample go straight to the shifters. Otherwise the idle word is sent.
  always_comb begin
    w_src       = LOAD_NONE;
    w_load_word = IDLE_PATTERN;
    if (w_load_edge) begin
      if (r_hold_full) begin
        w_src       = LOAD_HOLD;
        w_load_word = r_hold;
      end else if (w_xfer) begin
        w_src       = LOAD_BYPASS;
        w_load_word = i_s_data;
      end else begin
        w_src       = LOAD_IDLE;
        w_load_word = IDLE_PATTERN;
      end
    end
  end

  assign w_lane1_word = N'(lane_bits(MAX_SAMPLE_W'(w_load_word), 1));
  assign w_lane0_word = N'(lane_bits(MAX_SAMPLE_W'(w_load_word), 0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= CNT_LAST;
      r_hold_full   <= 1'b0;
      r_hold        <= '0;
      r_fr          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_next;
      r_fr          <= (int'(w_cnt_next) < FR_BITS);
      r_frame_start <= w_load_edge;

      unique case (w_src)
        LOAD_HOLD: begin
          r_hold_full <= w_xfer;
          if (w_xfer) begin
            r_hold <= i_s_data;
          end
        end
        LOAD_NONE: begin
          if (w_xfer) begin
            r_hold_full <= 1'b1;
            r_hold      <= i_s_data;
          end
        end
        default: begin
          r_hold_full <= r_hold_full;
        end
      endcase

      // If a set and a clear land on the same edge, the set wins.
      if (w_src == LOAD_IDLE) begin
        r_underrun <= 1'b1;
      end else if (i_clear_underrun) begin
        r_underrun <= 1'b0;
      end
    end
  end

  adc_lane_shift #(.N(N)) u_lane0 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load_edge),
    .i_data (w_lane0_word),
    .o_bit  (o_ln0)
  );

  adc_lane_shift #(.N(N)) u_lane1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load_edge),
    .i_data (w_lane1_word),
    .o_bit  (o_ln1)
  );

  assign o_fr          = r_fr;
  assign o_frame_start = r_frame_start;
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_adc_lane_tx.sv
// Self-checking bench for adc_lane_tx. It runs directed scenarios and then
// random traffic against a frame-level reference model.
module tb_adc_lane_tx;
  import adc_pkg::*;

  localparam int          W    = 16;
  localparam int          N    = 8;
  localparam int          FRB  = 4;
  localparam logic [15:0] IDLE = 16'hA5A5;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_s_data;
  logic        i_s_valid;
  logic        o_s_ready;
  logic        i_clear_underrun;
  logic        o_ln0;
  logic        o_ln1;
  logic        o_fr;
  logic        o_frame_start;
  logic        o_underrun;

  adc_lane_tx dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_s_data         (i_s_data),
    .i_s_valid        (i_s_valid),
    .o_s_ready        (o_s_ready),
    .i_clear_underrun (i_clear_underrun),
    .o_ln0            (o_ln0),
    .o_ln1            (o_ln1),
    .o_fr             (o_fr),
    .o_frame_start    (o_frame_start),
    .o_underrun       (o_underrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checksRun    = 0;
  int checksPassed = 0;

  // The model tracks the frame position, the word currently on the wire,
  // samples waiting to go out, and the sticky underrun flag.
  int          mPos  = N - 1;
  bit          mHave = 1'b0;
  logic [15:0] mCur  = '0;
  logic [15:0] mPend[$];
  bit          mUnd  = 1'b0;
  logic [15:0] sentQ[$];

  // The decoder rebuilds whole words from the DUT lanes.
  int          decIdx  = N;
  logic [15:0] decWord = '0;
  logic [15:0] decQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksRun++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Compare the registered outputs mid-cycle and feed the lane decoder.
  task automatic compareCycle();
    logic eLn1, eLn0, eFr, eFs;
    eLn1 = 1'b0; eLn0 = 1'b0; eFr = 1'b0; eFs = 1'b0;
    if (mHave) begin
      eLn1 = mCur[W-1-2*mPos];
      eLn0 = mCur[W-2-2*mPos];
      eFr  = (mPos < FRB);
      eFs  = (mPos == 0);
    end
    checkOutput("lanes", {o_ln1, o_ln0, o_fr, o_frame_start, o_underrun},
                {eLn1, eLn0, eFr, eFs, mUnd});
    checkOutput("sReady", o_s_ready, (!i_rst && mPend.size() == 0));

    if (!mHave) decIdx = N;
    if (o_frame_start) decIdx = 0;
    if (decIdx < N) begin
      decWord = {decWord[13:0], o_ln1, o_ln0};
      decIdx++;
      if (decIdx == N) begin
        decQ.push_back(decWord);
        checkOutput("frameWordPresent", sentQ.size(), 1);
        if (sentQ.size() > 0) checkOutput("frameWord", decWord, sentQ.pop_front());
      end
    end
  endtask

  // Advance the model by one rising edge using the inputs presented to it.
  task automatic modelEdge();
    bit xfer;
    bit idleLoad;
    if (i_rst) begin
      mPend.delete();
      sentQ.delete();
      mHave = 1'b0;
      mPos  = N - 1;
      mUnd  = 1'b0;
    end else begin
      xfer     = i_s_valid && (mPend.size() == 0);
      idleLoad = 1'b0;
      if (xfer) mPend.push_back(i_s_data);
      if (mPos == N - 1) begin
        mHave = 1'b1;
        if (mPend.size() > 0) begin
          mCur = mPend.pop_front();
        end else begin
          mCur     = IDLE;
          idleLoad = 1'b1;
        end
        sentQ.push_back(mCur);
        mPos = 0;
      end else begin
        mPos++;
      end
      if (idleLoad) mUnd = 1'b1;
      else if (i_clear_underrun) mUnd = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    compareCycle();
    @(posedge i_clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input logic [15:0] data,
                               input bit clear, input bit rst);
    i_s_valid        = valid;
    i_s_data         = data;
    i_clear_underrun = clear;
    i_rst            = rst;
    tick();
  endtask

  task automatic alignTo(input int pos);
    for (int i = 0; i < N + 1 && mPos != pos; i++) applyStimulus(0, '0, 0, 0);
  endtask

  task automatic expectDecoded(input string tag, input logic [15:0] word);
    checkOutput({tag, "Count"}, (decQ.size() > 0), 1);
    if (decQ.size() > 0) checkOutput(tag, decQ.pop_front(), word);
  endtask

  initial begin
    int nextSample;
    bit curValid;
    logic [15:0] curData;

    i_rst = 1'b1; i_s_valid = 1'b0; i_s_data = '0; i_clear_underrun = 1'b0;
    @(posedge i_clk);
    modelEdge();
    #1;
    applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 0, 1);

    $display("[TB] idle frame after reset release");
    decQ.delete();
    for (int i = 0; i < 10; i++) applyStimulus(0, '0, 0, 0);
    expectDecoded("idleFrame", IDLE);
    checkOutput("underrunSet", o_underrun, 1);

    $display("[TB] bypass on a load edge");
    alignTo(N - 1);
    applyStimulus(1, 16'hB38C, 0, 0);
    checkOutput("bypassLatency", {o_frame_start, o_ln1, o_ln0}, 3'b110);
    decQ.delete();
    for (int i = 0; i < 9; i++) applyStimulus(0, '0, 0, 0);
    expectDecoded("bypassFrame", 16'hB38C);

    $display("[TB] back-to-back samples 1..5");
    alignTo(N - 1);
    applyStimulus(1, 16'd1, 1, 0);
    decQ.delete();
    nextSample = 2;
    for (int i = 0; i < 60 && nextSample <= 5; i++) begin
      applyStimulus(1, 16'(nextSample), 0, 0);
      if (mPend.size() == 1 && mPend[0] == 16'(nextSample)) begin
        checkOutput("readyLowAfterAccept", o_s_ready, 0);
        nextSample++;
      end
    end
    checkOutput("noUnderrunStream", o_underrun, 0);
    for (int i = 0; i < 3 * N; i++) applyStimulus(0, '0, 0, 0);
    for (int s = 1; s <= 5; s++) expectDecoded("streamFrame", 16'(s));

    $display("[TB] underrun clear versus idle load");
    alignTo(N - 1);
    applyStimulus(0, '0, 1, 0);
    checkOutput("clearLosesToSet", o_underrun, 1);
    applyStimulus(0, '0, 1, 0);
    checkOutput("clearTakesEffect", o_underrun, 0);

    $display("[TB] reset mid-frame with a held sample");
    alignTo(N - 1);
    applyStimulus(1, 16'h1111, 0, 0);
    applyStimulus(1, 16'h5A3C, 0, 0);
    alignTo(3);
    applyStimulus(0, '0, 0, 1);
    checkOutput("rstOutputs", {o_ln1, o_ln0, o_fr, o_frame_start, o_underrun, o_s_ready}, 0);
    applyStimulus(0, '0, 0, 1);
    decQ.delete();
    applyStimulus(0, '0, 0, 0);
    checkOutput("restartFrameStart", {o_frame_start, o_fr}, 2'b11);
    for (int i = 0; i < 9; i++) applyStimulus(0, '0, 0, 0);
    expectDecoded("heldDropped", IDLE);

    $display("[TB] random traffic");
    curValid = 1'b0;
    curData  = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!(curValid && mPend.size() != 0)) begin
        curValid = ($urandom_range(0, 99) < 55);
        curData  = 16'($urandom);
      end
      applyStimulus(curValid, curData, ($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 399) == 0));
    end
    for (int i = 0; i < 2 * N; i++) applyStimulus(0, '0, 0, 0);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule

// File: doc/adc_lane_tx.md
# adc_lane_tx

Two-lane ADC transmit serializer. It is the source-side counterpart of the two-lane LVDS ADC input path. It accepts parallel samples over a valid/ready stream and serializes each one, MSB-first and bit-interleaved, onto lanes `ln0`/`ln1`, with a free-running frame marker `fr`. It feeds the board's differential output buffers for ADC emulation and receive-path loopback testing, and it inserts an idle pattern when the source underruns.

## Interface
- `SAMPLE_W`, 16, sample width in bits; must be even and ≥ 4; N = SAMPLE_W/2 bits per lane per frame.
- `IDLE_PATTERN`, 16'hA5A5 (SAMPLE_W bits), word sent when no sample is available at a frame boundary.

Ports:
- `clk`  in  1  bit clock; one bit per lane per cycle (SDR).
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  SAMPLE_W  sample to transmit.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  holding register can accept a sample.
- `clear_underrun`  in  1  clears the `underrun` flag.
- `ln0`  out  1  lane 0 serial data (even bits).
- `ln1`  out  1  lane 1 serial data (odd bits).
- `fr`  out  1  frame marker, high for the first ceil(N/2) bits of each frame.
- `frame_start`  out  1  one-cycle pulse aligned with bit 0 of each frame.
- `underrun`  out  1  sticky flag: at least one idle frame was sent.

## Operation
- Reset values:
  - `ln0`, `ln1`, `fr`, `frame_start`, `underrun`: 0.
  - `s_ready`: 0 while `rst` is high.
  - Holding register: empty.
  - Bit counter `cnt`: N-1, so the first edge after reset is a load edge.
- Handshake:
  - `s_ready` = holding register empty and not `rst`.
  - A transfer occurs on a rising edge with `s_valid` & `s_ready`.
  - `s_data` must stay stable while `s_valid` is high and `s_ready` is low.
- Load edge (any edge where `cnt` == N-1): the word loaded into the lane shifters is chosen in priority order:
  1. The holding register, if full. The register empties. A simultaneous transfer refills it.
  2. Else, if a transfer occurs on this edge, `s_data` goes directly to the shifters (bypass). The holding register stays empty.
  3. Else, `IDLE_PATTERN` is loaded and `underrun` is set.
- Bit mapping for word D:
  - `ln1` carries D[W-1], D[W-3], …, D[1].
  - `ln0` carries D[W-2], D[W-4], …, D[0].
  - Both lanes are sent MSB-first.
- `cnt` wraps from N-1 to 0 and increments every cycle. The frame is free-running and never stalls.
- `underrun`: set on an idle load; cleared by `clear_underrun`. If set and clear occur on the same edge, set wins.
- Reset asserted mid-frame: the frame is abandoned, any held sample is dropped, and all outputs return to reset values on that edge.

## Timing
- All outputs are registered except `s_ready`.
- In the cycle after a load edge, outputs show frame bit k=0:
  - `ln1`=D[W-1], `ln0`=D[W-2], `frame_start`=1, `fr`=1.
- At bit k: `ln1`=D[W-1-2k], `ln0`=D[W-2-2k].
- `fr`=1 for k < ceil(N/2), else 0.
- Minimum latency: a sample taken via bypass on a load edge has its first bit visible 1 cycle later.
- Maximum buffering: 1 held sample plus 1 in flight.
- Steady-state throughput: 1 sample per N cycles. `s_ready` returns high on the load edge that drains the holding register.

## Structure
- Package `adc_pkg` holds:
  - lane-count constant `ADC_LANES = 2`;
  - default `SAMPLE_W` and idle-pattern constants;
  - a function that splits a sample into per-lane words (odd bits / even bits).
- Sub-module `adc_lane_shift`: N-bit parallel-load, MSB-first shift register, instantiated once per lane.
- The top level holds `cnt`, the holding register, the load-select logic, `fr`/`frame_start`, and `underrun`.
- Differential output buffers are not part of this block.

## Test plan
All scenarios use SAMPLE_W=16 (N=8) and `IDLE_PATTERN`=16'hA5A5.
- Reset release, `s_valid`=0 → the first frame is idle:
  - `ln1` = 1,1,0,0,1,1,0,0; `ln0` = 0,0,1,1,0,0,1,1;
  - `fr` high for bits 0–3; `frame_start` on bit 0;
  - `underrun`=1.
- 16'hB38C presented on a load edge (bypass) → the next frame shows `ln1` = 1,1,0,1,1,0,1,0 and `ln0` = 0,1,0,1,0,0,1,0; latency 1 cycle.
- Continuous `s_valid` with samples 1..5 → back-to-back frames with no idle:
  - `s_ready` is low from each accept until the next load edge;
  - `underrun` stays 0.
- `underrun` set, then `clear_underrun` asserted:
  - on the same edge as an idle load → the flag stays 1;
  - on a later edge with no idle load → the flag is 0.
- `rst` pulsed at bit 3 with a sample held → all outputs are 0 during reset; the held sample is never transmitted; the next frame starts one cycle after the first non-reset edge.
- Random `s_valid` stalls → the decoded lane stream equals the accepted sample sequence with idle words inserted only at underruns.
